// File: rtl/sipo_frame_ctrl.sv
// sipo_frame_ctrl: start/data/stop sequencer driving an external SIPO shift register,
// with a single-entry valid/ready output buffer. Define SIPO_PARITY_EN for an even-parity bit.
module sipo_frame_ctrl #(
    parameter int DATA_W  = 8,
    parameter int BIT_DIV = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_serial_in,
    input  logic [DATA_W-1:0] i_par_in,
    output logic              o_shift_en,
    output logic [DATA_W-1:0] o_out_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic              o_frame_err,
    output logic              o_overrun,
    output logic              o_busy
);
    localparam int HALF   = (BIT_DIV - 1) / 2;
    localparam int TMR_W  = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam int BCNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [TMR_W-1:0]  TMR_HALF  = TMR_W'(HALF);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(BIT_DIV - 1);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(DATA_W - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd4;
`ifdef SIPO_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif

    logic [2:0]        r_state;
    logic [TMR_W-1:0]  r_tmr;
    logic [BCNT_W-1:0] r_bcnt;
    logic              r_shift_en;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;
    logic              r_frame_err;
    logic              r_overrun;
    logic              r_busy;

    logic [2:0]        w_state_nx;
    logic [TMR_W-1:0]  w_tmr_nx;
    logic [BCNT_W-1:0] w_bcnt_nx;
    logic              w_shift;
    logic              w_ferr;
    logic              w_load;
    logic              w_ovr;
    logic              w_buf_free;
    logic              w_stop_armed;

`ifdef SIPO_PARITY_EN
    logic r_par;
    logic r_perr;
    logic w_par_nx;
    logic w_perr_nx;

    // A frame already rejected on parity must not be judged again at its stop bit.
    assign w_stop_armed = ~r_perr;
`else
    assign w_stop_armed = 1'b1;
`endif

    // A consumer draining the buffer on the stop-sample cycle frees it for the new word.
    assign w_buf_free = ~r_out_valid | i_out_ready;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_nx = r_state;
        w_tmr_nx   = (r_tmr == TMR_LAST) ? '0 : r_tmr + TMR_W'(1);
        w_bcnt_nx  = r_bcnt;
        w_shift    = 1'b0;
        w_ferr     = 1'b0;
        w_load     = 1'b0;
        w_ovr      = 1'b0;
`ifdef SIPO_PARITY_EN
        w_par_nx   = r_par;
        w_perr_nx  = r_perr;
`endif
        case (r_state)
            S_IDLE: begin
                w_tmr_nx  = '0;
                w_bcnt_nx = '0;
                if (!i_serial_in) begin
                    w_state_nx = S_START;
`ifdef SIPO_PARITY_EN
                    w_par_nx   = 1'b0;
                    w_perr_nx  = 1'b0;
`endif
                end
            end
            S_START: begin
                if (r_tmr == TMR_HALF && i_serial_in) begin
                    w_state_nx = S_IDLE;
                    w_tmr_nx   = '0;
                end else if (r_tmr == TMR_LAST) begin
                    w_state_nx = S_DATA;
                    w_bcnt_nx  = '0;
                end
            end
            S_DATA: begin
                if (r_tmr == TMR_HALF) begin
                    w_shift  = 1'b1;
`ifdef SIPO_PARITY_EN
                    w_par_nx = r_par ^ i_serial_in;
`endif
                end
                if (r_tmr == TMR_LAST) begin
                    if (r_bcnt == BCNT_LAST) begin
                        w_bcnt_nx  = '0;
`ifdef SIPO_PARITY_EN
                        w_state_nx = S_PARITY;
`else
                        w_state_nx = S_STOP;
`endif
                    end else begin
                        w_bcnt_nx = r_bcnt + BCNT_W'(1);
                    end
                end
            end
`ifdef SIPO_PARITY_EN
            S_PARITY: begin
                if (r_tmr == TMR_HALF && (r_par ^ i_serial_in)) begin
                    w_ferr    = 1'b1;
                    w_perr_nx = 1'b1;
                end
                if (r_tmr == TMR_LAST) begin
                    w_state_nx = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // Leave right after the mid-bit sample so a back-to-back start edge is not missed.
                if (r_tmr == TMR_HALF) begin
                    w_state_nx = S_IDLE;
                    w_tmr_nx   = '0;
                    if (w_stop_armed) begin
                        if (!i_serial_in) begin
                            w_ferr = 1'b1;
                        end else if (w_buf_free) begin
                            w_load = 1'b1;
                        end else begin
                            w_ovr = 1'b1;
                        end
                    end
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_tmr_nx   = '0;
                w_bcnt_nx  = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_tmr       <= '0;
            r_bcnt      <= '0;
            r_shift_en  <= 1'b0;
            // NOTE: the buffered word is cleared on reset so the data output reads zero, not stale content.
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_busy      <= 1'b0;
`ifdef SIPO_PARITY_EN
            r_par       <= 1'b0;
            r_perr      <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nx;
            r_tmr       <= w_tmr_nx;
            r_bcnt      <= w_bcnt_nx;
            r_shift_en  <= w_shift;
            r_frame_err <= w_ferr;
            r_overrun   <= w_ovr;
            r_busy      <= (w_state_nx != S_IDLE);
`ifdef SIPO_PARITY_EN
            r_par       <= w_par_nx;
            r_perr      <= w_perr_nx;
`endif
            if (w_load) begin
                r_out_data  <= i_par_in;
                r_out_valid <= 1'b1;
            end else if (r_out_valid && i_out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign o_shift_en  = r_shift_en;
    assign o_out_data  = r_out_data;
    assign o_out_valid = r_out_valid;
    assign o_frame_err = r_frame_err;
    assign o_overrun   = r_overrun;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Self-checking bench for sipo_frame_ctrl: directed frames plus randomized traffic,
// compared every cycle against a time-offset model of the frame rules.
module tb_sipo_frame_ctrl;
    localparam int DATA_W  = 8;
    localparam int BIT_DIV = 4;
    localparam int HALF    = (BIT_DIV - 1) / 2;
`ifdef SIPO_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    // Edge offsets from the edge that first sees the start bit low.
    localparam int FIRST_SHIFT = BIT_DIV + HALF + 1;
    localparam int PAR_AT      = BIT_DIV * (DATA_W + 1) + HALF + 1;
    localparam int STOP_AT     = BIT_DIV * (DATA_W + 1 + PAR_BITS) + HALF + 1;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              serial_in = 1'b1;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] par_in    = '0;
    logic              shift_en;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              frame_err;
    logic              overrun;
    logic              busy;

    sipo_frame_ctrl #(.DATA_W(DATA_W), .BIT_DIV(BIT_DIV)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_serial_in (serial_in),
        .i_par_in    (par_in),
        .o_shift_en  (shift_en),
        .o_out_data  (out_data),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_frame_err (frame_err),
        .o_overrun   (overrun),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    // External shift register the controller sequences.
    always @(posedge clk) begin
        if (shift_en) par_in <= {par_in[DATA_W-2:0], serial_in};
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    bit line_q[$];
    bit rdy_q[$];
    bit rst_q[$];

    // Model state
    bit                m_active, m_par, m_perr, m_bval, m_prev_shift;
    int                m_k;
    logic [DATA_W-1:0] m_bdata = '0;
    logic [DATA_W-1:0] m_msr   = '0;
    bit                e_shift, e_valid, e_ferr, e_ovr, e_busy;
    logic [DATA_W-1:0] e_data = '0;

    // Per-segment observations
    int                c_shift, c_ferr, c_ovr, c_busy, c_vhigh, n_xfer, bad_space, last_shift;
    logic [DATA_W-1:0] last_xfer;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input bit l, input int n, input int rmode);
        for (int i = 0; i < n; i++) begin
            line_q.push_back(l);
            rdy_q.push_back(rmode == 2 ? bit'($urandom_range(0, 1)) : bit'(rmode));
            rst_q.push_back(1'b1);
        end
    endtask

    task automatic push_reset();
        line_q.push_back(1'b1);
        rdy_q.push_back(1'b1);
        rst_q.push_back(1'b0);
    endtask

    task automatic push_frame(input logic [DATA_W-1:0] b, input bit stop, input bit par_ok, input int rmode);
        logic p;
        push(1'b0, BIT_DIV, rmode);
        for (int i = DATA_W - 1; i >= 0; i--) push(b[i], BIT_DIV, rmode);
        p = ^b;
        if (!par_ok) p = ~p;
        if (PAR_BITS != 0) push(p, BIT_DIV, rmode);
        push(stop, BIT_DIV, rmode);
    endtask

    task automatic push_partial(input logic [DATA_W-1:0] b, input int nbits, input int extra);
        push(1'b0, BIT_DIV, 1);
        for (int i = 0; i < nbits; i++) push(b[DATA_W-1-i], BIT_DIV, 1);
        push(b[DATA_W-1-nbits], extra, 1);
    endtask

    task automatic seg_clear();
        c_shift = 0; c_ferr = 0; c_ovr = 0; c_busy = 0; c_vhigh = 0;
        n_xfer = 0; bad_space = 0; last_shift = -1; last_xfer = '0;
    endtask

    // Frame rules expressed as edge offsets from start detection.
    task automatic model_step(input bit l, input bit r, input bit n);
        bit load;
        bit shift_now;
        int d;
        shift_now = m_prev_shift;
        load = 1'b0; e_shift = 1'b0; e_ferr = 1'b0; e_ovr = 1'b0;
        if (!n) begin
            m_active = 1'b0; m_bval = 1'b0; m_bdata = '0;
        end else if (!m_active) begin
            if (!l) begin
                m_active = 1'b1; m_k = cyc; m_par = 1'b0; m_perr = 1'b0;
            end
        end else begin
            d = cyc - m_k;
            if (d == HALF + 1 && l) begin
                m_active = 1'b0;
            end else if (d >= FIRST_SHIFT && d < FIRST_SHIFT + DATA_W * BIT_DIV
                         && (d - FIRST_SHIFT) % BIT_DIV == 0) begin
                e_shift = 1'b1;
                m_par ^= l;
            end else if (PAR_BITS != 0 && d == PAR_AT) begin
                if (m_par ^ l) begin e_ferr = 1'b1; m_perr = 1'b1; end
            end else if (d == STOP_AT) begin
                m_active = 1'b0;
                if (!m_perr) begin
                    if (!l) e_ferr = 1'b1;
                    else if (!m_bval || r) load = 1'b1;
                    else e_ovr = 1'b1;
                end
            end
        end
        if (n) begin
            if (load) begin m_bval = 1'b1; m_bdata = m_msr; end
            else if (m_bval && r) m_bval = 1'b0;
        end
        e_busy = m_active; e_valid = m_bval; e_data = m_bdata;
        if (shift_now) m_msr = {m_msr[DATA_W-2:0], l};
        m_prev_shift = e_shift;
    endtask

    task automatic step();
        @(negedge clk);
        serial_in = line_q.pop_front();
        out_ready = rdy_q.pop_front();
        rst_n     = rst_q.pop_front();
        if (out_valid && out_ready && rst_n) begin
            n_xfer++;
            last_xfer = out_data;
        end
        @(posedge clk);
        model_step(serial_in, out_ready, rst_n);
        #1;
        check("shift_en",  {31'd0, shift_en},  {31'd0, e_shift});
        check("out_valid", {31'd0, out_valid}, {31'd0, e_valid});
        check("out_data",  32'(out_data),      32'(e_data));
        check("frame_err", {31'd0, frame_err}, {31'd0, e_ferr});
        check("overrun",   {31'd0, overrun},   {31'd0, e_ovr});
        check("busy",      {31'd0, busy},      {31'd0, e_busy});
        if (!rst_n) check("reset_clears_outputs",
                          32'({out_data, shift_en, out_valid, frame_err, overrun, busy}), 32'd0);
        if (shift_en) begin
            if (last_shift >= 0 && cyc - last_shift != BIT_DIV) bad_space++;
            last_shift = cyc;
            c_shift++;
        end
        if (frame_err) c_ferr++;
        if (overrun)   c_ovr++;
        if (busy)      c_busy++;
        if (out_valid) c_vhigh++;
        cyc++;
    endtask

    task automatic run();
        while (line_q.size() > 0) step();
    endtask

    initial begin
        seg_clear();
        push_reset(); push_reset(); push_reset();
        push(1'b1, 4, 1);
        run();

        // 0xA5, good stop, consumer always ready
        seg_clear();
        push_frame(8'hA5, 1'b1, 1'b1, 1);
        push(1'b1, 6, 1);
        run();
        check("a5_shift_count", c_shift, 8);
        check("a5_shift_spacing_errors", bad_space, 0);
        check("a5_valid_cycles", c_vhigh, 1);
        check("a5_transfers", n_xfer, 1);
        check("a5_data", 32'(last_xfer), 32'hA5);
        check("a5_frame_err", c_ferr, 0);
        check("a5_overrun", c_ovr, 0);

        // one-cycle glitch in idle
        seg_clear();
        push(1'b1, 3, 1); push(1'b0, 1, 1); push(1'b1, 6, 1);
        run();
        check("glitch_shift_count", c_shift, 0);
        check("glitch_busy_cycles", c_busy, 2);
        check("glitch_busy_final", {31'd0, busy}, 0);

        // bad stop bit
        seg_clear();
        push_frame(8'h3C, 1'b0, 1'b1, 1);
        push(1'b1, 6, 1);
        run();
        check("badstop_frame_err", c_ferr, 1);
        check("badstop_valid_cycles", c_vhigh, 0);
        check("badstop_transfers", n_xfer, 0);

        // full buffer: second frame overruns, first word held
        seg_clear();
        push_frame(8'h11, 1'b1, 1'b1, 0);
        push_frame(8'h22, 1'b1, 1'b1, 0);
        push(1'b1, 4, 0);
        run();
        check("ovr_count", c_ovr, 1);
        check("ovr_held_data", 32'(out_data), 32'h11);
        check("ovr_valid_held", {31'd0, out_valid}, 1);
        check("ovr_no_transfer", n_xfer, 0);
        seg_clear();
        push(1'b1, 4, 1);
        run();
        check("drain_transfers", n_xfer, 1);
        check("drain_data", 32'(last_xfer), 32'h11);
        check("drain_valid_final", {31'd0, out_valid}, 0);

        // reset in the middle of data bit 4, then 0xFF
        seg_clear();
        push_partial(8'h5A, 4, 2);
        push_reset();
        push(1'b1, 6, 1);
        push_frame(8'hFF, 1'b1, 1'b1, 1);
        push(1'b1, 6, 1);
        run();
        check("rst_ff_transfers", n_xfer, 1);
        check("rst_ff_data", 32'(last_xfer), 32'hFF);
        check("rst_ff_frame_err", c_ferr, 0);

`ifdef SIPO_PARITY_EN
        seg_clear();
        push_frame(8'h07, 1'b1, 1'b1, 1);
        push(1'b1, 6, 1);
        run();
        check("par_ok_transfers", n_xfer, 1);
        check("par_ok_data", 32'(last_xfer), 32'h07);
        check("par_ok_frame_err", c_ferr, 0);
        seg_clear();
        push_frame(8'h07, 1'b1, 1'b0, 1);
        push(1'b1, 6, 1);
        run();
        check("par_bad_frame_err", c_ferr, 1);
        check("par_bad_valid_cycles", c_vhigh, 0);
`endif

        // randomized traffic against the model
        seg_clear();
        for (int f = 0; f < 60; f++) begin
            int sel;
            sel = $urandom_range(0, 19);
            if (sel == 0) begin
                push(1'b0, 1, 2);
                push(1'b1, 3 + $urandom_range(0, 3), 2);
            end else if (sel == 1) begin
                push_partial(DATA_W'($urandom), $urandom_range(0, DATA_W - 1), $urandom_range(0, BIT_DIV - 1));
                push_reset();
                push(1'b1, 2 + $urandom_range(0, 3), 2);
            end else begin
                bit stop_ok;
                bit par_ok;
                stop_ok = ($urandom_range(0, 9) != 0);
                par_ok  = ($urandom_range(0, 9) != 0);
                push_frame(DATA_W'($urandom), stop_ok, par_ok, 2);
                push(1'b1, $urandom_range(0, 5) + (stop_ok ? 0 : 3), 2);
            end
        end
        push(1'b1, 4, 1);
        run();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sipo_frame_ctrl.md
# sipo_frame_ctrl

Frame controller that sequences the 8-bit serial-to-parallel shift register on one clock. It detects a start bit on the serial line and pulses the shift register's shift enable at each data-bit midpoint. It then checks the stop bit and captures the completed parallel word into a single-entry output buffer with a valid/ready handshake. It sits between the serial pad and the downstream parallel consumer, and flags framing errors and buffer overruns.

## Interface
- DATA_W, 8, data bits per frame; must equal the shift register width.
- BIT_DIV, 4, clock cycles per serial bit (≥1). Sample point HALF = (BIT_DIV-1)/2, integer division.
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- serial_in  in  1  serial line; idles high.
- par_in  in  DATA_W  parallel word from the shift register; registered, updates the cycle after shift_en.
- shift_en  out  1  one-cycle pulse; the shift register shifts serial_in in at its LSB.
- out_data  out  DATA_W  buffered frame word.
- out_valid  out  1  out_data holds an unconsumed word.
- out_ready  in  1  consumer accepts the word when out_valid && out_ready.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: a good frame was dropped because the buffer was full.
- busy  out  1  FSM is not in IDLE.

## Operation
- Frame format: start (0), DATA_W data bits MSB first, optional parity, stop (1).
- FSM states: IDLE, START, DATA, [PARITY], STOP. All states use a timer tmr counting 0..BIT_DIV-1 and a bit counter bcnt counting 0..DATA_W-1.
- IDLE: when serial_in==0 → START, with tmr=0.
- START: at tmr==HALF, if serial_in==1 this is a false start → IDLE, with no pulses. At tmr==BIT_DIV-1 → DATA, with bcnt=0.
- DATA: at tmr==HALF, shift_en=1 for exactly one cycle. At tmr==BIT_DIV-1, if bcnt==DATA_W-1 → next state (PARITY or STOP); otherwise bcnt+1.
- STOP: at tmr==HALF, evaluate the stop bit and go → IDLE on the next cycle. The rest of the stop period is not waited out.
  - serial_in==0: frame_err=1; word discarded.
  - serial_in==1 and the buffer is free: out_data←par_in and out_valid←1. The buffer is free when out_valid==0, or out_valid && out_ready in the same cycle.
  - serial_in==1 and the buffer is full: overrun=1; the old word is kept unchanged.
- Handshake: out_valid clears on out_valid && out_ready unless a load happens in the same cycle. out_data is stable while out_valid==1 && out_ready==0.
- Reset, including mid-frame: FSM→IDLE, tmr=bcnt=0. All outputs are 0: shift_en, out_data, out_valid, frame_err, overrun, busy. The partially shifted contents of the shift register are ignored.

## Timing
- Frame length: (DATA_W+2)*BIT_DIV cycles, plus BIT_DIV with parity. The FSM returns to IDLE HALF+1 cycles after the stop period begins.
- The first shift_en occurs BIT_DIV+HALF+1 cycles after the cycle serial_in is first sampled low in IDLE.
- out_valid rises the cycle after the stop sample.
- BIT_DIV=1: HALF=0. Every state samples on its first cycle, and shift_en is high for DATA_W consecutive cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- SIPO_PARITY_EN defined:
  - Adds the PARITY state after DATA. The controller accumulates the XOR of the data bits at their sample points.
  - At PARITY tmr==HALF, an even-parity mismatch pulses frame_err and discards the frame. The STOP state is still traversed, so it cannot also flag a stop error for the same frame.
- Not defined: there is no PARITY state, and the frame length is (DATA_W+2)*BIT_DIV cycles.

## Test plan
- BIT_DIV=4, send 0xA5 with stop=1, out_ready=1:
  - exactly 8 shift_en pulses, spaced 4 cycles apart;
  - out_valid pulses for one cycle with out_data=0xA5;
  - frame_err=0 and overrun=0.
- Glitch: serial_in low for 1 cycle only in IDLE → FSM returns to IDLE at START tmr==1; no shift_en; busy drops.
- Send 0x3C with stop=0 → frame_err pulses once; out_valid stays 0.
- out_ready=0, send 0x11 then 0x22 → out_data=0x11 is held, overrun pulses at the second stop. Then raise out_ready → one transfer of 0x11 only.
- Assert rst_n=0 for one cycle at data bit 4 of a frame → all outputs 0 next cycle. A following frame 0xFF is received correctly.
- SIPO_PARITY_EN defined, send 0x07 with parity bit 1 → out_data=0x07. The same frame with parity bit 0 → frame_err pulse and no out_valid.
